// File: rtl/sequence_generator_0110.sv
// Serial frame transmitter: preamble 0110, payload MSB-first, then idle-level gap bits.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit after the payload.
module sequence_generator_0110 #(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             preamble_active,
    output logic             frame_done,
    output logic [2:0]       o_dbg_state
);
    // Handshake: a word transfers on a rising edge where word_valid && word_ready;
    // word_ready depends only on state and reset, so upstream holds the word until it is taken.

    // The counter also has to span the 4 preamble bits and the gap.
    localparam int CNT_A = ($clog2(WIDTH + 1) > 2) ? $clog2(WIDTH + 1) : 2;
    localparam int CNT_W = ($clog2(GAP_CYCLES + 1) > CNT_A) ? $clog2(GAP_CYCLES + 1) : CNT_A;
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(3);
    // Bit k of this pattern is sent k-th; 0110 is a palindrome.
    localparam logic [3:0] PREAMBLE_BITS = 4'b0110;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_PAYLOAD  = 3'd2,
        S_PARITY   = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_data_out;
    logic             r_bit_valid;
    logic             r_preamble;
    logic             r_frame_done;

    state_t           w_state_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic [WIDTH-1:0] w_shift_n;
    logic             w_data_n;
    logic             w_bit_valid_n;
    logic             w_preamble_n;
    logic             w_frame_done_n;
    state_t           w_after_frame;

`ifdef SEQ_GEN_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (r_state == S_IDLE && word_valid) begin
            r_parity <= ^word_in;
        end
    end
`endif

    assign w_after_frame = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_shift_n = r_shift;
        case (r_state)
            S_IDLE: begin
                if (word_valid) begin
                    w_state_n = S_PREAMBLE;
                    w_cnt_n   = '0;
                    w_shift_n = word_in;
                end
            end
            S_PREAMBLE: begin
                if (r_cnt == PRE_LAST) begin
                    w_state_n = S_PAYLOAD;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_PAYLOAD: begin
                if (r_cnt == PAY_LAST) begin
                    w_cnt_n = '0;
`ifdef SEQ_GEN_PARITY_EN
                    w_state_n = S_PARITY;
`else
                    w_state_n = w_after_frame;
`endif
                end else begin
                    w_cnt_n   = r_cnt + CNT_W'(1);
                    w_shift_n = r_shift << 1;
                end
            end
            S_PARITY: begin
                w_state_n = w_after_frame;
                w_cnt_n   = '0;
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    // Line outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_data_n       = IDLE_LEVEL;
        w_bit_valid_n  = 1'b0;
        w_preamble_n   = 1'b0;
        w_frame_done_n = 1'b0;
        case (w_state_n)
            S_PREAMBLE: begin
                w_data_n      = PREAMBLE_BITS[w_cnt_n[1:0]];
                w_bit_valid_n = 1'b1;
                w_preamble_n  = 1'b1;
            end
            S_PAYLOAD: begin
                w_data_n      = w_shift_n[WIDTH-1];
                w_bit_valid_n = 1'b1;
`ifndef SEQ_GEN_PARITY_EN
                w_frame_done_n = (w_cnt_n == PAY_LAST);
`endif
            end
`ifdef SEQ_GEN_PARITY_EN
            S_PARITY: begin
                w_data_n       = r_parity;
                w_bit_valid_n  = 1'b1;
                w_frame_done_n = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_data_out   <= IDLE_LEVEL;
            r_bit_valid  <= 1'b0;
            r_preamble   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_shift      <= w_shift_n;
            r_data_out   <= w_data_n;
            r_bit_valid  <= w_bit_valid_n;
            r_preamble   <= w_preamble_n;
            r_frame_done <= w_frame_done_n;
        end
    end

    assign word_ready      = (r_state == S_IDLE) && !reset;
    assign data_out        = r_data_out;
    assign bit_valid       = r_bit_valid;
    assign preamble_active = r_preamble;
    assign frame_done      = r_frame_done;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_sequence_generator_0110.sv
// Directed bench for sequence_generator_0110: default 8-bit/gap-2 instance plus a 4-bit/gap-0 instance.
module tb_sequence_generator_0110;
    localparam int GAP = 2;
`ifdef SEQ_GEN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN  = 12 + PAR;
    localparam int F2LEN = 8 + PAR;
    localparam int S2    = FLEN + GAP + 1;

    typedef struct {
        logic [7:0]  word;
        logic [11:0] frame;
        logic        par;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] word_in = 8'h00;
    logic       word_valid = 1'b0;
    logic       word_ready, data_out, bit_valid, preamble_active, frame_done;
    logic [2:0] dbg_state;

    logic [3:0] w2_in = 4'h0;
    logic       v2 = 1'b0;
    logic       r2, d2, bv2, pa2, fd2;
    logic [2:0] st2;

    int checks = 0;
    int errors = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    sequence_generator_0110 #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) dut (
        .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .data_out(data_out), .bit_valid(bit_valid),
        .preamble_active(preamble_active), .frame_done(frame_done), .o_dbg_state(dbg_state)
    );

    sequence_generator_0110 #(.WIDTH(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut2 (
        .clk(clk), .reset(reset), .word_in(w2_in), .word_valid(v2),
        .word_ready(r2), .data_out(d2), .bit_valid(bv2),
        .preamble_active(pa2), .frame_done(fd2), .o_dbg_state(st2)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!word_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!word_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready actual=0 required=1 after %0d cycles", n);
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input logic [11:0] frame, input logic par);
        logic exp_bit;
        wait_ready();
        word_in    = w;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            exp_bit = (i < 12) ? frame[11-i] : par;
            check("data_out", data_out, exp_bit);
            check("bit_valid", bit_valid, 1'b1);
            check("preamble_active", preamble_active, i < 4);
            check("frame_done", frame_done, i == FLEN - 1);
            check("word_ready_busy", word_ready, 1'b0);
            // A competing word offered mid-frame must not disturb the frame.
            if (i == 5) begin
                word_valid = 1'b1;
                word_in    = ~w;
            end
            if (i == FLEN - 1) word_valid = 1'b0;
            @(negedge clk);
        end
        for (int g = 0; g < GAP; g++) begin
            check("gap_data", data_out, 1'b1);
            check("gap_bit_valid", bit_valid, 1'b0);
            check("gap_ready", word_ready, 1'b0);
            @(negedge clk);
        end
        check("ready_after_gap", word_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] f1;
        logic [11:0] f2;
        logic [7:0]  f3;
        logic [3:0]  hist;
        logic        exp_bit;

        vecs[0] = '{8'hA5, 12'b0110_1010_0101, 1'b0};
        vecs[1] = '{8'h07, 12'b0110_0000_0111, 1'b1};
        vecs[2] = '{8'h03, 12'b0110_0000_0011, 1'b0};
        vecs[3] = '{8'h66, 12'b0110_0110_0110, 1'b0};
        vecs[4] = '{8'h5A, 12'b0110_0101_1010, 1'b0};
        vecs[5] = '{8'h80, 12'b0110_1000_0000, 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_data_out", data_out, 1'b1);
        check("rst_bit_valid", bit_valid, 1'b0);
        check("rst_preamble", preamble_active, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_ready_low", word_ready, 1'b0);
        check("rst_state_idle", dbg_state == 3'd0, 1'b1);
        reset = 1'b0;
        #1;
        check("ready_after_reset", word_ready, 1'b1);
        check("dut2_ready_after_reset", r2, 1'b1);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].word, vecs[v].frame, vecs[v].par);
        end

        // Back-to-back FF then 00 with a loopback 0110 detector on the line
        f1   = 12'b0110_1111_1111;
        f2   = 12'b0110_0000_0000;
        hist = 4'hF;
        wait_ready();
        word_in    = 8'hFF;
        word_valid = 1'b1;
        @(negedge clk);
        word_in = 8'h00;
        for (int k = 0; k < S2 + FLEN + GAP + 1; k++) begin
            if (k < 12) exp_bit = f1[11-k];
            else if (k < FLEN) exp_bit = 1'b0;
            else if (k < S2) exp_bit = 1'b1;
            else if (k < S2 + 12) exp_bit = f2[11-(k-S2)];
            else if (k < S2 + FLEN) exp_bit = 1'b0;
            else exp_bit = 1'b1;
            check("b2b_data", data_out, exp_bit);
            check("b2b_preamble", preamble_active, (k < 4) || (k >= S2 && k < S2 + 4));
            if (k == S2 - 1) check("b2b_ready", word_ready, 1'b1);
            hist = {hist[2:0], data_out};
            check("loopback_detect", hist == 4'b0110, (k == 3) || (k == S2 + 3));
            if (k == S2) word_valid = 1'b0;
            @(negedge clk);
        end

        // Reset during payload bit 3 of 3C, then a clean 81
        wait_ready();
        word_in    = 8'h3C;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_bit3", data_out, 1'b1);
        check("abort_bv_before", bit_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_data_idle", data_out, 1'b1);
        check("abort_bit_valid", bit_valid, 1'b0);
        check("abort_preamble", preamble_active, 1'b0);
        check("abort_frame_done", frame_done, 1'b0);
        check("abort_ready_in_reset", word_ready, 1'b0);
        check("abort_state_idle", dbg_state == 3'd0, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_ready_after", word_ready, 1'b1);
        send_frame(8'h81, 12'b0110_1000_0001, 1'b0);

        // WIDTH=4, GAP_CYCLES=0 instance: word 9, then re-accept one cycle after frame_done
        f3    = 8'b0110_1001;
        w2_in = 4'h9;
        v2    = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        for (int i = 0; i < F2LEN; i++) begin
            exp_bit = (i < 8) ? f3[7-i] : 1'b0;
            check("w4_data", d2, exp_bit);
            check("w4_bit_valid", bv2, 1'b1);
            check("w4_preamble", pa2, i < 4);
            check("w4_frame_done", fd2, i == F2LEN - 1);
            check("w4_ready_busy", r2, 1'b0);
            @(negedge clk);
        end
        check("w4_idle_data", d2, 1'b1);
        check("w4_idle_bv", bv2, 1'b0);
        check("w4_ready", r2, 1'b1);
        w2_in = 4'h6;
        v2    = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        check("w4_second_start", d2, 1'b0);
        check("w4_second_preamble", pa2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
